// File: rtl/dmem_ctrl.sv
// Data-memory access controller: load/store requests from the core to a word-wide
// single-port RAM, with sub-word load extraction and read-modify-write sub-word stores.
module dmem_ctrl #(
  parameter int unsigned ADDRESS_WIDTH = 12,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     rsp_err,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-3:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wd,
  input  logic [DATA_WIDTH-1:0]    mem_rd
);

  typedef enum logic [2:0] {IDLE, READ, DATA, WRITE, RESP} state_t;

  state_t          state;
  logic            we_q;
  logic [2:0]      funct3_q;
  logic [1:0]      lane_q;
  logic [15:0]     wdata_q;

  logic                  illegal_c;
  logic [7:0]            byte_c;
  logic [15:0]           half_c;
  logic [DATA_WIDTH-1:0] load_c;
  logic [DATA_WIDTH-1:0] merge_c;

  assign req_ready = (state == IDLE);

  // Reject unsupported funct3 codes and misaligned halfword/word accesses.
  always_comb begin
    illegal_c = 1'b0;
    if (req_we) illegal_c = (req_funct3 > 3'b010);
    else        illegal_c = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    if ((req_funct3[1:0] == 2'b01) && req_addr[0])          illegal_c = 1'b1;
    if ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)) illegal_c = 1'b1;
  end

  // Lane extraction for loads and lane merge for sub-word stores, both from mem_rd.
  always_comb begin
    byte_c  = mem_rd[{lane_q, 3'b000} +: 8];
    half_c  = lane_q[1] ? mem_rd[31:16] : mem_rd[15:0];
    load_c  = mem_rd;
    merge_c = mem_rd;
    case (funct3_q[1:0])
      2'b00:   load_c = {{(DATA_WIDTH-8){byte_c[7] & ~funct3_q[2]}}, byte_c};
      2'b01:   load_c = {{(DATA_WIDTH-16){half_c[15] & ~funct3_q[2]}}, half_c};
      default: load_c = mem_rd;
    endcase
    if (funct3_q[1:0] == 2'b00) merge_c[{lane_q, 3'b000} +: 8]        = wdata_q[7:0];
    else                        merge_c[{lane_q[1], 4'b0000} +: 16]   = wdata_q[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      funct3_q  <= 3'b000;
      lane_q    <= 2'b00;
      wdata_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wd    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            lane_q   <= req_addr[1:0];
            wdata_q  <= req_wdata[15:0];
            if (illegal_c) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              state     <= RESP;
            end else begin
              mem_addr <= req_addr[ADDRESS_WIDTH-1:2];
              // Full-word stores need no read and go straight to the write cycle.
              if (req_we && (req_funct3 == 3'b010)) begin
                mem_we <= 1'b1;
                mem_wd <= req_wdata;
                state  <= WRITE;
              end else begin
                state  <= READ;
              end
            end
          end
        end
        READ: state <= DATA;
        DATA: begin
          if (!we_q) begin
            rsp_rdata <= load_c;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            mem_wd <= merge_c;
            mem_we <= 1'b1;
            state  <= WRITE;
          end
        end
        WRITE: begin
          mem_we    <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          state     <= RESP;
        end
        RESP: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed scenarios plus randomized traffic
// against a byte-lane reference model of the memory.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic        ram_init;
  logic [31:0] ram     [0:1023];
  logic [31:0] ref_mem [0:1023];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.ADDRESS_WIDTH(12), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  function automatic logic [31:0] init_word(int i);
    return (32'(i) * 32'h9E3779B9) ^ 32'h13579BDF;
  endfunction

  // Synchronous-read single-port RAM seen by the controller.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 1024; i++) ram[i] <= init_word(i);
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wd;
    end
    mem_rd <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference behaviour from access size, alignment and byte lanes.
  task automatic model(input bit we, input logic [2:0] f3, input logic [11:0] addr,
                       input logic [31:0] wdata, output bit err, output int lat,
                       output logic [31:0] rdata, output bit wr, output logic [31:0] wd);
    int size, sh;
    logic [31:0] word, mask, val;
    size = 1 << f3[1:0];
    sh   = 8 * int'(addr[1:0]);
    word = ref_mem[addr[11:2]];
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    if (we) err = (f3 > 3'd2);
    else    err = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if ((int'(addr) % size) != 0) err = 1'b1;
    rdata = 32'h0; wr = 1'b0; wd = 32'h0;
    if (err) begin
      lat = 1;
    end else if (!we) begin
      lat = 3;
      val = (word >> sh) & mask;
      if (!f3[2] && size < 4 && val[8*size-1]) val = val | ~mask;
      rdata = val;
    end else begin
      wr  = 1'b1;
      lat = (size == 4) ? 2 : 4;
      wd  = (size == 4) ? wdata : ((word & ~(mask << sh)) | ((wdata & mask) << sh));
    end
  endtask

  // One request from an idle controller; inputs driven and outputs sampled 1 after posedge.
  task automatic transact(input bit we, input logic [2:0] f3, input logic [11:0] addr,
                          input logic [31:0] wdata, output logic [31:0] got_rdata,
                          output logic [31:0] got_wd);
    bit e_err, e_wr, busy_ok;
    int e_lat, cyc, n_wr, wr_cyc, guard;
    logic [31:0] e_rd, e_wd;
    logic [9:0] wr_addr, rd_addr;
    model(we, f3, addr, wdata, e_err, e_lat, e_rd, e_wr, e_wd);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    guard = 0;
    while (!req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    check("ready_before_req", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_wr = 0; wr_cyc = 0; busy_ok = 1'b1; got_wd = 32'h0; wr_addr = '0;
    rd_addr = mem_addr;
    for (cyc = 1; cyc <= 8; cyc++) begin
      if (req_ready) busy_ok = 1'b0;
      if (mem_we) begin n_wr++; wr_cyc = cyc; wr_addr = mem_addr; got_wd = mem_wd; end
      if (rsp_valid) break;
      @(posedge clk); #1;
    end
    got_rdata = rsp_rdata;
    check("rsp_latency", 32'(cyc), 32'(e_lat));
    check("rsp_err", 32'(rsp_err), 32'(e_err));
    check("rsp_rdata", rsp_rdata, e_rd);
    check("ready_busy", 32'(busy_ok), 32'h1);
    check("write_count", 32'(n_wr), e_wr ? 32'h1 : 32'h0);
    if (e_wr) begin
      check("write_cycle", 32'(wr_cyc), 32'(e_lat - 1));
      check("write_addr", 32'(wr_addr), 32'(addr[11:2]));
      check("write_data", got_wd, e_wd);
      ref_mem[addr[11:2]] = e_wd;
    end
    if (!e_err && !(we && f3 == 3'd2)) check("read_addr", 32'(rd_addr), 32'(addr[11:2]));
    @(posedge clk); #1;
    check("rsp_pulse", 32'(rsp_valid), 32'h0);
    check("ready_after", 32'(req_ready), 32'h1);
  endtask

  initial begin
    logic [31:0] rd, wd, first_rd, w_wd, e6_rd, e6_wd;
    bit e_err, e_wr, quiet;
    int e_lat, rsp_cnt, first_cyc, second_cyc, w_cyc, c;
    bit busy_bad;

    rst = 1'b1; ram_init = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_mem_wd", mem_wd, 32'h0);
    rst = 1'b0; ram_init = 1'b0;
    @(posedge clk); #1;
    check("ready_out_of_reset", 32'(req_ready), 32'h1);

    // Full-word store then every load flavour on the same word.
    transact(1'b1, 3'd2, 12'h010, 32'hDEADBEEF, rd, wd);
    check("sw_wd_const", wd, 32'hDEADBEEF);
    transact(1'b0, 3'd0, 12'h013, 32'h0, rd, wd); check("lb_const", rd, 32'hFFFFFFDE);
    transact(1'b0, 3'd4, 12'h013, 32'h0, rd, wd); check("lbu_const", rd, 32'h000000DE);
    transact(1'b0, 3'd1, 12'h012, 32'h0, rd, wd); check("lh_const", rd, 32'hFFFFDEAD);
    transact(1'b0, 3'd5, 12'h012, 32'h0, rd, wd); check("lhu_const", rd, 32'h0000DEAD);
    transact(1'b0, 3'd2, 12'h010, 32'h0, rd, wd); check("lw_const", rd, 32'hDEADBEEF);

    // Sub-word read-modify-write stores.
    transact(1'b1, 3'd0, 12'h011, 32'h12345655, rd, wd); check("sb_wd_const", wd, 32'hDEAD55EF);
    transact(1'b1, 3'd1, 12'h012, 32'h0000CAFE, rd, wd); check("sh_wd_const", wd, 32'hCAFE55EF);
    transact(1'b0, 3'd2, 12'h010, 32'h0, rd, wd); check("lw_after_rmw", rd, 32'hCAFE55EF);

    // Illegal requests leave the RAM alone.
    transact(1'b0, 3'd2, 12'h012, 32'h0, rd, wd);
    transact(1'b1, 3'd1, 12'h011, 32'hFFFFFFFF, rd, wd);
    transact(1'b0, 3'd3, 12'h010, 32'h0, rd, wd);
    transact(1'b1, 3'd4, 12'h010, 32'hFFFFFFFF, rd, wd);
    transact(1'b0, 3'd2, 12'h010, 32'h0, rd, wd); check("lw_after_illegal", rd, 32'hCAFE55EF);

    // Reset during the DATA cycle of a byte store.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 12'h011; req_wdata = 32'hAA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_rdata", rsp_rdata, 32'h0);
    quiet = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      if (mem_we || rsp_valid) quiet = 1'b0;
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (mem_we || rsp_valid) quiet = 1'b0;
    end
    check("abort_quiet", 32'(quiet), 32'h1);
    check("abort_ready", 32'(req_ready), 32'h1);
    transact(1'b0, 3'd2, 12'h010, 32'h0, rd, wd); check("lw_after_abort", rd, 32'hCAFE55EF);

    // Back-to-back: LW with valid held, then SW queued behind it.
    model(1'b0, 3'd2, 12'h010, 32'h0, e_err, e_lat, e6_rd, e_wr, wd);
    model(1'b1, 3'd2, 12'h014, 32'h0BADF00D, e_err, e_lat, rd, e_wr, e6_wd);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 12'h010; req_wdata = 32'h0;
    @(posedge clk); #1;
    req_we = 1'b1; req_addr = 12'h014; req_wdata = 32'h0BADF00D;
    rsp_cnt = 0; first_cyc = 0; second_cyc = 0; w_cyc = 0; busy_bad = 1'b0;
    first_rd = 32'h0; w_wd = 32'h0;
    for (c = 1; c <= 10; c++) begin
      if (c == 5) req_valid = 1'b0;
      if (c <= 3 && req_ready) busy_bad = 1'b1;
      if (mem_we) begin w_cyc = c; w_wd = mem_wd; end
      if (rsp_valid) begin
        rsp_cnt++;
        if (rsp_cnt == 1) begin first_cyc = c; first_rd = rsp_rdata; end
        else second_cyc = c;
      end
      if (rsp_cnt == 2) break;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    check("b2b_busy", 32'(busy_bad), 32'h0);
    check("b2b_first_cycle", 32'(first_cyc), 32'd3);
    check("b2b_first_rdata", first_rd, e6_rd);
    check("b2b_write_cycle", 32'(w_cyc), 32'd5);
    check("b2b_write_data", w_wd, e6_wd);
    check("b2b_second_cycle", 32'(second_cyc), 32'd6);
    ref_mem[12'h014 >> 2] = e6_wd;
    @(posedge clk); #1;
    transact(1'b0, 3'd2, 12'h014, 32'h0, rd, wd); check("lw_after_b2b", rd, 32'h0BADF00D);

    // Randomized traffic over a small window so loads hit earlier stores.
    for (int n = 0; n < 200; n++) begin
      transact(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               12'($urandom_range(0, 63)), $urandom, rd, wd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
